// File: rtl/cart_bus_arbiter.sv
// Two-port arbiter and phase sequencer for the external cartridge bus.
// Port A (core) and port B (aux agent) alternate on ties; each access runs setup/strobe/hold/done.
module cart_bus_arbiter #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [15:0] a_addr,
   input  logic [7:0]  a_wdata,
   output logic        a_ack,
   output logic [7:0]  a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [15:0] b_addr,
   input  logic [7:0]  b_wdata,
   output logic        b_ack,
   output logic [7:0]  b_rdata,
   output logic [15:0] bus_a,
   output logic [7:0]  bus_dout,
   output logic        bus_doe,
   input  logic [7:0]  bus_din,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic        bus_cs,
   output logic        busy
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             cmd_we;
   logic             cur_b;
   logic             last_b;
   logic [7:0]       rd_reg;

   logic             gnt_b_c;
   logic             sel_we_c;
   logic [15:0]      sel_addr_c;
   logic [7:0]       sel_wdata_c;

   // Grant B when it is alone, or when both request and A was served last.
   always_comb begin
      gnt_b_c     = b_req && (!a_req || !last_b);
      sel_we_c    = a_we;
      sel_addr_c  = a_addr;
      sel_wdata_c = a_wdata;
      if (gnt_b_c) begin
         sel_we_c    = b_we;
         sel_addr_c  = b_addr;
         sel_wdata_c = b_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         cmd_we   <= 1'b0;
         cur_b    <= 1'b0;
         last_b   <= 1'b1;
         rd_reg   <= '0;
         a_ack    <= 1'b0;
         a_rdata  <= '0;
         b_ack    <= 1'b0;
         b_rdata  <= '0;
         bus_a    <= '0;
         bus_dout <= '0;
         bus_doe  <= 1'b0;
         bus_rd   <= 1'b0;
         bus_wr   <= 1'b0;
         bus_cs   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  state   <= SETUP;
                  cnt     <= SETUP_LD;
                  cur_b   <= gnt_b_c;
                  last_b  <= gnt_b_c;
                  cmd_we  <= sel_we_c;
                  bus_a   <= sel_addr_c;
                  bus_cs  <= (sel_addr_c[15:13] == 3'b101);
                  bus_doe <= sel_we_c;
                  busy    <= 1'b1;
                  if (sel_we_c) begin
                     bus_dout <= sel_wdata_c;
                  end
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state  <= STROBE;
                  cnt    <= STROBE_LD;
                  bus_rd <= !cmd_we;
                  bus_wr <= cmd_we;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            STROBE: begin
               // Read data is taken on the edge that closes the last strobe cycle.
               if (cnt == '0) begin
                  state  <= HOLD;
                  cnt    <= HOLD_LD;
                  bus_rd <= 1'b0;
                  bus_wr <= 1'b0;
                  rd_reg <= bus_din;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state   <= DONE;
                  bus_cs  <= 1'b0;
                  bus_doe <= 1'b0;
                  if (cur_b) begin
                     b_ack <= 1'b1;
                     if (!cmd_we) begin
                        b_rdata <= rd_reg;
                     end
                  end else begin
                     a_ack <= 1'b1;
                     if (!cmd_we) begin
                        a_rdata <= rd_reg;
                     end
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               a_ack <= 1'b0;
               b_ack <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Bench for cart_bus_arbiter: transaction-offset model compared every cycle, plus directed scenarios.
module tb_cart_bus_arbiter;

   localparam int S1 = 1, T1 = 2, H1 = 1;
   localparam int S2 = 3, T2 = 4, H2 = 2;

   typedef struct packed {
      logic [7:0]  off;
      logic        gb;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [7:0]  rdr;
      logic        lb;
      logic [7:0]  ard;
      logic [7:0]  brd;
      logic [15:0] ba;
   } mst_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata, din1;
   logic        a_ack, b_ack, bus_doe, bus_rd, bus_wr, bus_cs, busy;
   logic [7:0]  a_rdata, b_rdata, bus_dout;
   logic [15:0] bus_a;

   logic        c_req, c_we;
   logic [15:0] c_addr;
   logic [7:0]  c_wdata, din2;
   logic        z_req, z_we;
   logic [15:0] z_addr;
   logic [7:0]  z_wdata;
   logic        c_ack, d_ack, bus2_doe, bus2_rd, bus2_wr, bus2_cs, busy2;
   logic [7:0]  c_rdata, d_rdata, bus2_dout;
   logic [15:0] bus2_a;

   cart_bus_arbiter u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .bus_a(bus_a), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(din1),
      .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_cs(bus_cs), .busy(busy)
   );

   cart_bus_arbiter #(.SETUP_CYC(S2), .STROBE_CYC(T2), .HOLD_CYC(H2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata), .a_ack(c_ack), .a_rdata(c_rdata),
      .b_req(z_req), .b_we(z_we), .b_addr(z_addr), .b_wdata(z_wdata), .b_ack(d_ack), .b_rdata(d_rdata),
      .bus_a(bus2_a), .bus_dout(bus2_dout), .bus_doe(bus2_doe), .bus_din(din2),
      .bus_rd(bus2_rd), .bus_wr(bus2_wr), .bus_cs(bus2_cs), .busy(busy2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: an access is a count of edges since grant; phase follows from that offset.
   function automatic mst_t m_reset();
      mst_t m = '0;
      m.lb = 1'b1;
      return m;
   endfunction

   function automatic mst_t m_step(input mst_t m, input int s, input int t, input int h,
                                   input logic ar, input logic awe, input logic [15:0] aad, input logic [7:0] awd,
                                   input logic br, input logic bwe, input logic [15:0] bad, input logic [7:0] bwd,
                                   input logic [7:0] din);
      mst_t n = m;
      int   len = s + t + h + 1;
      int   o = int'(m.off);
      if (o == 0) begin
         if (ar || br) begin
            n.gb   = br && (!ar || !m.lb);
            n.lb   = n.gb;
            n.we   = n.gb ? bwe : awe;
            n.addr = n.gb ? bad : aad;
            n.wd   = n.gb ? bwd : awd;
            n.ba   = n.addr;
            n.off  = 8'd1;
         end
      end else if (o == len) begin
         n.off = 8'd0;
      end else begin
         n.off = 8'(o + 1);
         if (o == s + t) n.rdr = din;
         if (o + 1 == len && !m.we) begin
            if (m.gb) n.brd = m.rdr;
            else      n.ard = m.rdr;
         end
      end
      return n;
   endfunction

   mst_t m1, m2;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= m_reset();
         m2 <= m_reset();
      end else begin
         m1 <= m_step(m1, S1, T1, H1, a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, din1);
         m2 <= m_step(m2, S2, T2, H2, c_req, c_we, c_addr, c_wdata, z_req, z_we, z_addr, z_wdata, din2);
      end
   end

   task automatic cmp(input string tg, input mst_t m, input int s, input int t, input int h,
                      input logic aack, input logic [7:0] ard, input logic back, input logic [7:0] brd,
                      input logic [15:0] ba, input logic [7:0] dout, input logic doe,
                      input logic rd, input logic wr, input logic cs, input logic bsy);
      int  o   = int'(m.off);
      int  len = s + t + h + 1;
      bit  acc = (o >= 1) && (o <= s + t + h);
      bit  stb = (o > s) && (o <= s + t);
      chk({tg, ".busy"},    32'(bsy),  32'(o != 0));
      chk({tg, ".a_ack"},   32'(aack), 32'(o == len && !m.gb));
      chk({tg, ".b_ack"},   32'(back), 32'(o == len && m.gb));
      chk({tg, ".a_rdata"}, 32'(ard),  32'(m.ard));
      chk({tg, ".b_rdata"}, 32'(brd),  32'(m.brd));
      chk({tg, ".bus_a"},   32'(ba),   32'(m.ba));
      chk({tg, ".bus_doe"}, 32'(doe),  32'(acc && m.we));
      chk({tg, ".bus_cs"},  32'(cs),   32'(acc && m.addr[15:13] == 3'b101));
      chk({tg, ".bus_rd"},  32'(rd),   32'(stb && !m.we));
      chk({tg, ".bus_wr"},  32'(wr),   32'(stb && m.we));
      if (acc && m.we) chk({tg, ".bus_dout"}, 32'(dout), 32'(m.wd));
   endtask

   int rd_n = 0, wr_n = 0, cs_n = 0, doe_n = 0, aack_n = 0, rd2_n = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         cmp("d1", m1, S1, T1, H1, a_ack, a_rdata, b_ack, b_rdata, bus_a, bus_dout, bus_doe,
             bus_rd, bus_wr, bus_cs, busy);
         cmp("d2", m2, S2, T2, H2, c_ack, c_rdata, d_ack, d_rdata, bus2_a, bus2_dout, bus2_doe,
             bus2_rd, bus2_wr, bus2_cs, busy2);
         if (bus_rd && bus_wr) chk("rd_wr_both", 32'd1, 32'd0);
         rd_n   += int'(bus_rd);
         wr_n   += int'(bus_wr);
         cs_n   += int'(bus_cs);
         doe_n  += int'(bus_doe);
         aack_n += int'(a_ack);
         rd2_n  += int'(bus2_rd);
      end
   end

   // Wait for ack on port 0 (A), 1 (B) or 2 (second instance A); deassert req at the sampling edge.
   task automatic wait_ack(input int port, output int lat);
      bit got = 0;
      lat = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         got = (port == 0) ? a_ack : (port == 1) ? b_ack : c_ack;
      end
      if (!got) chk($sformatf("ack_timeout_p%0d", port), 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (port == 0) a_req = 1'b0;
      else if (port == 1) b_req = 1'b0;
      else c_req = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   int la, lb, lc, s_rd, s_wr, s_cs, s_doe, s_ack, s_rd2;
   bit ord [4];
   int nord;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      {a_req, a_we, b_req, b_we, c_req, c_we, z_req, z_we} = '0;
      {a_addr, b_addr, c_addr, z_addr} = '0;
      {a_wdata, b_wdata, c_wdata, z_wdata, din1, din2} = '0;
      #3;
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.bus_a", 32'(bus_a), 32'd0);
      chk("rst.strobes", 32'({bus_rd, bus_wr, bus_cs, bus_doe}), 32'd0);
      chk("rst.acks", 32'({a_ack, b_ack, a_rdata, b_rdata}), 32'd0);
      #14 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Port A read of 0x0147
      a_we = 1'b0; a_addr = 16'h0147; din1 = 8'h03;
      s_rd = rd_n; s_cs = cs_n; s_doe = doe_n;
      a_req = 1'b1;
      wait_ack(0, la);
      chk("t1.lat", 32'(la), 32'd5);
      chk("t1.rdata", 32'(a_rdata), 32'h03);
      chk("t1.rd_cycles", 32'(rd_n - s_rd), 32'd2);
      chk("t1.cs_cycles", 32'(cs_n - s_cs), 32'd0);
      chk("t1.doe_cycles", 32'(doe_n - s_doe), 32'd0);

      // Port B write 0x5A to 0xA010
      b_we = 1'b1; b_addr = 16'hA010; b_wdata = 8'h5A;
      s_rd = rd_n; s_wr = wr_n; s_cs = cs_n; s_doe = doe_n;
      b_req = 1'b1;
      wait_ack(1, lb);
      chk("t2.lat", 32'(lb), 32'd5);
      chk("t2.cs_cycles", 32'(cs_n - s_cs), 32'd4);
      chk("t2.doe_cycles", 32'(doe_n - s_doe), 32'd4);
      chk("t2.wr_cycles", 32'(wr_n - s_wr), 32'd2);
      chk("t2.rd_cycles", 32'(rd_n - s_rd), 32'd0);
      chk("t2.dout", 32'(bus_dout), 32'h5A);
      chk("t2.b_rdata", 32'(b_rdata), 32'h00);

      // Simultaneous requests from reset: A first, then B; next tie goes to A again
      pulse_reset();
      @(posedge clk);
      #1;
      a_we = 1'b0; a_addr = 16'h0134; b_we = 1'b0; b_addr = 16'hB000; din1 = 8'h77;
      for (int r = 0; r < 2; r++) begin
         a_req = 1'b1; b_req = 1'b1;
         fork
            wait_ack(0, la);
            wait_ack(1, lb);
         join
         chk($sformatf("t3.lat_a%0d", r), 32'(la), 32'd5);
         chk($sformatf("t3.lat_b%0d", r), 32'(lb), 32'd11);
         @(posedge clk);
         #1;
      end

      // Continuous requests on both ports must alternate
      din1 = 8'h21;
      a_req = 1'b1; b_req = 1'b1;
      nord = 0;
      for (int i = 0; i < 60 && nord < 4; i++) begin
         @(negedge clk);
         if (a_ack) begin ord[nord] = 1'b0; nord++; end
         else if (b_ack) begin ord[nord] = 1'b1; nord++; end
      end
      @(posedge clk);
      #1 a_req = 1'b0; b_req = 1'b0;
      chk("t4.acks", 32'(nord), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("t4.order%0d", i), 32'(ord[i]), 32'(i % 2));
      @(posedge clk);
      #1;

      // Asynchronous reset during the second strobe cycle of a write
      a_we = 1'b1; a_addr = 16'h4000; a_wdata = 8'hC5;
      a_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t5.wr_before", 32'(bus_wr), 32'd1);
      a_req = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("t5.wr_drop", 32'(bus_wr), 32'd0);
      chk("t5.doe_drop", 32'(bus_doe), 32'd0);
      chk("t5.busy_drop", 32'(busy), 32'd0);
      #1 rst_n = 1'b1;
      s_ack = aack_n;
      repeat (8) @(negedge clk);
      chk("t5.no_ack", 32'(aack_n - s_ack), 32'd0);
      @(posedge clk);
      #1;
      a_we = 1'b0; a_addr = 16'h0100; din1 = 8'h9E;
      a_req = 1'b1;
      wait_ack(0, la);
      chk("t5.lat", 32'(la), 32'd5);
      chk("t5.rdata", 32'(a_rdata), 32'h9E);

      // Longer phases: capture happens on the edge closing the 4th strobe cycle
      din2 = 8'h11; c_we = 1'b0; c_addr = 16'h0200;
      s_rd2 = rd2_n;
      c_req = 1'b1;
      fork
         wait_ack(2, lc);
         begin
            repeat (6) @(posedge clk);
            #1 din2 = 8'hC3;
            repeat (2) @(posedge clk);
            #1 din2 = 8'h3C;
         end
      join
      chk("t6.lat", 32'(lc), 32'd10);
      chk("t6.rdata", 32'(c_rdata), 32'hC3);
      chk("t6.rd_cycles", 32'(rd2_n - s_rd2), 32'd4);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
